alu_issue: RTL and testbench

Operand-issue stage that drives the RV32I integer ALU. Accepts one instruction word per transfer, with its PC and register-file read data, over a valid/ready handshake. Decodes the OP, OP-IMM, LUI and AUIPC formats into the ALU's `func3`/`func` select and 32-bit A/B operands, then presents the result on a registered valid/ready output. Sits between register read and the ALU/writeback stage; a 2-entry skid buffer gives full throughput with a registered `in_ready`.

---
 rtl/rv32_pkg.sv | 38 +++
 rtl/alu_issue_decode.sv | 69 ++++++
 rtl/alu_issue.sv | 105 ++++++++++
 tb/tb_alu_issue.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I encodings and the decoded ALU-issue payload.
package rv32_pkg;

    localparam int unsigned XLEN_W  = 32;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned FUNC3_W = 3;

    // Major opcodes handled by the issue stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU func3 encodings
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [FUNC3_W-1:0] func3;
        logic               func;
        logic [XLEN_W-1:0]  alu_a;
        logic [XLEN_W-1:0]  alu_b;
        logic [RD_W-1:0]    rd;
        logic               rd_we;
        logic               illegal;
    } alu_issue_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of OP / OP-IMM / LUI / AUIPC into ALU select and operands.
module alu_issue_decode
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output alu_issue_t  dec_c
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic        legal;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'b0};

    // Format decode; illegal encodings collapse to a zero payload with no writeback
    always_comb begin
        dec_c = '0;
        legal = 1'b0;
        unique case (opc)
            OPC_OP: begin
                legal       = (f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL)));
                dec_c.func3 = f3;
                dec_c.func  = instr[30];
                dec_c.alu_a = rs1;
                dec_c.alu_b = rs2;
            end
            OPC_OP_IMM: begin
                if (f3 == F3_SLL)      legal = (f7 == F7_ZERO);
                else if (f3 == F3_SRL) legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
                else                   legal = 1'b1;
                dec_c.func3 = f3;
                // only shifts use the modifier; addi with imm[10]=1 stays an add
                dec_c.func  = (f3 == F3_SRL) ? instr[30] : 1'b0;
                dec_c.alu_a = rs1;
                dec_c.alu_b = imm_i;
            end
            OPC_LUI: begin
                legal       = 1'b1;
                dec_c.alu_b = imm_u;
            end
            OPC_AUIPC: begin
                legal       = 1'b1;
                dec_c.alu_a = pc;
                dec_c.alu_b = imm_u;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_c.func3 = F3_ADD;
            dec_c.func  = 1'b0;
            dec_c.alu_a = '0;
            dec_c.alu_b = '0;
        end
        dec_c.rd      = instr[11:7];
        dec_c.illegal = !legal;
        dec_c.rd_we   = legal && (instr[11:7] != 5'd0);
    end

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage: input decode feeding a 2-entry skid buffer toward the ALU.
module alu_issue
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_func3,
    output logic            out_func,
    output logic [XLEN-1:0] out_alu_a,
    output logic [XLEN-1:0] out_alu_b,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal
);

    alu_issue_t dec_c;
    alu_issue_t e0_q, e1_q, e0_d, e1_d;
    logic       v0_q, v1_q, v0_d, v1_d;
    logic       rdy_q, rdy_d;
    logic       acc, drain;

    alu_issue_decode u_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .dec_c (dec_c)
    );

    assign acc   = in_valid && rdy_q;
    assign drain = v0_q && out_ready;

    // Buffer next-state: flush first, then drain/refill, then plain accept
    always_comb begin
        e0_d = e0_q;
        e1_d = e1_q;
        v0_d = v0_q;
        v1_d = v1_q;
        if (flush) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end else if (drain) begin
            if (v1_q) begin
                e0_d = e1_q;
                v1_d = 1'b0;
                if (acc) begin
                    e1_d = dec_c;
                    v1_d = 1'b1;
                end
            end else if (acc) begin
                e0_d = dec_c;
            end else begin
                v0_d = 1'b0;
            end
        end else if (acc) begin
            if (!v0_q) begin
                e0_d = dec_c;
                v0_d = 1'b1;
            end else begin
                e1_d = dec_c;
                v1_d = 1'b1;
            end
        end
        rdy_d = !v1_d;
    end

    // Entry, valid and ready registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
            rdy_q <= 1'b1;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            v0_q  <= v0_d;
            v1_q  <= v1_d;
            rdy_q <= rdy_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = v0_q;
    assign out_func3   = e0_q.func3;
    assign out_func    = e0_q.func;
    assign out_alu_a   = e0_q.alu_a;
    assign out_alu_b   = e0_q.alu_b;
    assign out_rd      = e0_q.rd;
    assign out_rd_we   = e0_q.rd_we;
    assign out_illegal = e0_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, backpressure, flush and async reset.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1, in_rs2, out_alu_a, out_alu_b;
    logic [2:0]  out_func3;
    logic        out_func, out_rd_we, out_illegal;
    logic [4:0]  out_rd;
    logic [74:0] obs;
    int          vec = 0;
    int          errs = 0;

    assign obs = {out_func3, out_func, out_alu_a, out_alu_b, out_rd, out_rd_we, out_illegal};

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_func3(out_func3), .out_func(out_func),
        .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        in_rs1   = rs1;
        in_rs2   = rs2;
    endtask

    // add x(i+1),x1,x2 with rs1=100+i, rs2=i
    function automatic logic [31:0] add_instr(input int i);
        logic [31:0] base;
        base = 32'h0020_8033;
        return base | (32'(i + 1) << 7);
    endfunction

    function automatic logic [74:0] add_exp(input int i);
        return {3'b000, 1'b0, 32'(100 + i), 32'(i), 5'(i + 1), 1'b1, 1'b0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
        repeat (2) step();
        vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 75'd0) begin
            errs++;
            $display("FAIL reset: valid=%b ready=%b payload=%h, want 0 1 0", out_valid, in_ready, obs);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_op();
        logic [74:0] exp;
        out_ready = 1'b1;
        drive(32'h0020_81B3, 32'h0, 32'd5, 32'd7);
        step();
        in_valid = 1'b0;
        exp = {3'b000, 1'b0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
        vec++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            errs++;
            $display("FAIL add: valid=%b payload=%h, want 1 %h", out_valid, obs, exp);
        end
        step();
        vec++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL add_drain: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_op_imm();
        logic [74:0] exp;
        out_ready = 1'b1;
        drive(32'hFFF0_0093, 32'h0, 32'd9, 32'h55);
        step();
        drive(32'h4030_D113, 32'h0, 32'h80, 32'h66);
        exp = {3'b000, 1'b0, 32'd9, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0};
        vec++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            errs++;
            $display("FAIL addi: valid=%b payload=%h, want 1 %h", out_valid, obs, exp);
        end
        step();
        in_valid = 1'b0;
        exp = {3'b101, 1'b1, 32'h80, 32'h403, 5'd2, 1'b1, 1'b0};
        vec++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            errs++;
            $display("FAIL srai: valid=%b payload=%h, want 1 %h", out_valid, obs, exp);
        end
        step();
    endtask

    task automatic test_upper();
        logic [74:0] exp;
        out_ready = 1'b1;
        drive(32'h1234_52B7, 32'h200, 32'h11, 32'h22);
        step();
        drive(32'h0000_1317, 32'h100, 32'h33, 32'h44);
        exp = {3'b000, 1'b0, 32'h0, 32'h1234_5000, 5'd5, 1'b1, 1'b0};
        vec++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            errs++;
            $display("FAIL lui: valid=%b payload=%h, want 1 %h", out_valid, obs, exp);
        end
        step();
        in_valid = 1'b0;
        exp = {3'b000, 1'b0, 32'h100, 32'h1000, 5'd6, 1'b1, 1'b0};
        vec++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            errs++;
            $display("FAIL auipc: valid=%b payload=%h, want 1 %h", out_valid, obs, exp);
        end
        step();
    endtask

    task automatic test_illegal();
        logic [74:0] exp;
        out_ready = 1'b1;
        drive(32'h0001_2083, 32'h40, 32'd5, 32'd7);
        step();
        drive(32'h0220_81B3, 32'h44, 32'd5, 32'd7);
        exp = {3'b000, 1'b0, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1};
        vec++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            errs++;
            $display("FAIL ill_load: valid=%b payload=%h, want 1 %h", out_valid, obs, exp);
        end
        step();
        drive(32'h0020_8033, 32'h48, 32'd5, 32'd7);
        exp = {3'b000, 1'b0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1};
        vec++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            errs++;
            $display("FAIL ill_f7: valid=%b payload=%h, want 1 %h", out_valid, obs, exp);
        end
        step();
        in_valid = 1'b0;
        exp = {3'b000, 1'b0, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0};
        vec++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            errs++;
            $display("FAIL add_x0: valid=%b payload=%h, want 1 %h", out_valid, obs, exp);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int  idx = 0;
        int  got = 0;
        logic acc, drn;
        out_ready = 1'b0;
        // stall: only two of the four can be taken
        for (int c = 0; c < 5; c++) begin
            if (idx < 4) drive(add_instr(idx), 32'h0, 32'(100 + idx), 32'(idx));
            else in_valid = 1'b0;
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
            if (c == 1) begin
                vec++;
                if (in_ready !== 1'b0 || idx != 2) begin
                    errs++;
                    $display("FAIL bp_ready: ready=%b accepted=%0d, want 0 2", in_ready, idx);
                end
            end
        end
        vec++;
        if (out_valid !== 1'b1 || obs !== add_exp(0)) begin
            errs++;
            $display("FAIL bp_hold: valid=%b payload=%h, want 1 %h", out_valid, obs, add_exp(0));
        end
        // release and drain in FIFO order
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (idx < 4) drive(add_instr(idx), 32'h0, 32'(100 + idx), 32'(idx));
            else in_valid = 1'b0;
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn) begin
                vec++;
                if (obs !== add_exp(got)) begin
                    errs++;
                    $display("FAIL bp_order%0d: payload=%h, want %h", got, obs, add_exp(got));
                end
                got++;
            end
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        vec++;
        if (got != 4 || idx != 4) begin
            errs++;
            $display("FAIL bp_count: drained=%0d accepted=%0d, want 4 4", got, idx);
        end
        step();
        vec++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL bp_extra: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(add_instr(0), 32'h0, 32'd200, 32'd0);
        step();
        drive(add_instr(1), 32'h0, 32'd201, 32'd1);
        step();
        vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errs++;
            $display("FAIL fl_full: ready=%b valid=%b, want 0 1", in_ready, out_valid);
        end
        flush = 1'b1;
        drive(add_instr(2), 32'h0, 32'd202, 32'd2);
        step();
        flush = 1'b0; in_valid = 1'b0;
        vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL fl_full_clear: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        // flush while ready is high: the presented input must still be dropped
        drive(add_instr(3), 32'h0, 32'd203, 32'd3);
        step();
        flush = 1'b1;
        drive(add_instr(4), 32'h0, 32'd204, 32'd4);
        step();
        flush = 1'b0; in_valid = 1'b0;
        vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL fl_ready_clear: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vec++;
            if (out_valid !== 1'b0) begin
                errs++;
                $display("FAIL fl_ghost%0d: valid=%b, want 0", c, out_valid);
            end
        end
        vec++;
        if (out_alu_a !== 32'd203) begin
            errs++;
            $display("FAIL fl_hold: alu_a=%h, want %h", out_alu_a, 32'd203);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(add_instr(5), 32'h0, 32'd300, 32'd5);
        step();
        drive(add_instr(6), 32'h0, 32'd301, 32'd6);
        step();
        in_valid = 1'b0;
        vec++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL ar_pre: valid=%b ready=%b, want 1 0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 75'd0) begin
            errs++;
            $display("FAIL ar_async: valid=%b ready=%b payload=%h, want 0 1 0", out_valid, in_ready, obs);
        end
        step();
        rst_n = 1'b1;
        step();
        vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL ar_post: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_op();
        test_op_imm();
        test_upper();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
